// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, default reset PC, fetch FSM encoding
// and a small PC-increment helper used by the fetch path.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int ENTRY_W = 2 * WORD_W;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  // Word-addressed sequential successor, wrapping at the top of memory.
  function automatic logic [WORD_W-1:0] pc_incr(input logic [WORD_W-1:0] pc);
    return pc + {{(WORD_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue for the fetch stage: synchronous FIFO with push, pop,
// flush and occupancy count. Entries are {instruction, address}.
// Storage is sized for the largest legal depth (4); DEPTH selects how many
// entries are actually used.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [2:0]       count
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);
  localparam logic [2:0] CAP  = 3'(DEPTH);

  logic [WIDTH-1:0] mem [0:3];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Qualify requests: never pop when empty, never push into a full queue
  // unless an entry leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != 3'd0);
    do_push = push && ((count != CAP) || do_pop);
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues word-addressed reads to instruction
// memory (one outstanding at a time), queues responses in fetch_fifo and
// presents the head entry to decode. Branch redirects flush the queue and
// drop any response still in flight.
// Optional feature macro FETCH_BYPASS_EN: when the queue is empty a
// response arriving in WAIT is forwarded to decode in the same cycle.
module fetch
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Branch,
  input  logic [WORD_W-1:0] CalculatedPC,
  output logic              IMemReq,
  output logic [WORD_W-1:0] IMemAddr,
  input  logic              IMemValid,
  input  logic [WORD_W-1:0] IMemData,
  output logic [WORD_W-1:0] InstructOut,
  output logic [WORD_W-1:0] NextPCOut,
  output logic              InstructValid
);

  localparam logic [2:0] CAP = 3'(FIFO_DEPTH);

  fetch_state_t       state;
  fetch_state_t       next_state;
  logic [WORD_W-1:0]  pc;
  logic [WORD_W-1:0]  req_addr;
  logic               resp_accept;
  logic               bypass;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_rd;
  logic [2:0]         fifo_count;
  logic               head_valid;
  logic               room;

  assign head_valid = (fifo_count != 3'd0);
  assign room       = (fifo_count < CAP);
  assign IMemAddr   = pc;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state logic, request issue and response acceptance; a branch
  // suppresses issue and turns any in-flight response into a drop.
  always_comb begin
    next_state  = state;
    IMemReq     = 1'b0;
    resp_accept = 1'b0;
    case (state)
      S_FETCH: begin
        if (!rst && !Branch && room) begin
          IMemReq    = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IMemValid) begin
          resp_accept = !Branch && !rst;
          next_state  = S_FETCH;
        end else if (Branch) begin
          next_state = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (IMemValid) next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // PC and outstanding-request address; redirect wins over sequential issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else if (Branch) begin
      pc <= CalculatedPC;
    end else if (IMemReq) begin
      req_addr <= pc;
      pc       <= pc_incr(pc);
    end
  end

`ifdef FETCH_BYPASS_EN
  assign bypass    = resp_accept && !head_valid;
  assign fifo_push = resp_accept && (!bypass || Stall);
`else
  assign bypass    = 1'b0;
  assign fifo_push = resp_accept;
`endif

  assign fifo_pop = head_valid && !Stall && !Branch;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (Branch),
    .wr_data({IMemData, req_addr}),
    .rd_data(fifo_rd),
    .count  (fifo_count)
  );

  // Decode-facing outputs: bypassed word, else queue head, else all zero.
  always_comb begin
    InstructValid = 1'b0;
    InstructOut   = '0;
    NextPCOut     = '0;
    if (bypass) begin
      InstructValid = 1'b1;
      InstructOut   = IMemData;
      NextPCOut     = pc_incr(req_addr);
    end else if (head_valid) begin
      InstructValid = 1'b1;
      InstructOut   = fifo_rd[ENTRY_W-1:WORD_W];
      NextPCOut     = pc_incr(fifo_rd[WORD_W-1:0]);
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Testbench for fetch: a latency-programmable instruction memory model
// answers the DUT's requests, and a scoreboard queue of expected
// {instruction, address} entries is compared with the decode outputs.
`timescale 1ns/1ps
module tb_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        Branch;
  logic [15:0] CalculatedPC;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemValid;
  logic [15:0] IMemData;
  logic [15:0] InstructOut;
  logic [15:0] NextPCOut;
  logic        InstructValid;

  fetch #(.RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .Stall        (Stall),
    .Branch       (Branch),
    .CalculatedPC (CalculatedPC),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemValid    (IMemValid),
    .IMemData     (IMemData),
    .InstructOut  (InstructOut),
    .NextPCOut    (NextPCOut),
    .InstructValid(InstructValid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory environment
  int          lat = 1;
  bit          mem_busy = 0;
  int          mem_delay = 0;
  logic [15:0] mem_addr = 16'h0;
  bit          override_en = 0;
  logic [15:0] override_data = 16'h0;

  // reference model
  logic [15:0] m_pc = 16'h0;
  bit          m_pending = 0;
  bit          m_killed = 0;
  logic [15:0] m_pend_addr = 16'h0;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] data_for(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs,
  // then advance the memory environment and the reference model.
  task automatic applyStimulus(input bit stall, input bit branch, input logic [15:0] target);
    bit          mem_valid;
    bit          exp_valid;
    bit          exp_req;
    bit          bypass_hit;
    logic [15:0] exp_out;
    logic [15:0] exp_next;
    logic [15:0] resp_data;
    @(negedge clk);
    rst          = 1'b0;
    mem_valid    = mem_busy && (mem_delay == 1);
    Stall        = stall;
    Branch       = branch;
    CalculatedPC = target;
    IMemValid    = mem_valid;
    IMemData     = mem_valid ? (override_en ? override_data : data_for(mem_addr)) : 16'h0;
    #1;
    resp_data  = override_en ? override_data : data_for(m_pend_addr);
    exp_valid  = (exp_q.size() != 0);
    exp_out    = exp_valid ? exp_q[0][31:16] : 16'h0;
    exp_next   = exp_valid ? exp_q[0][15:0] + 16'd1 : 16'h0;
    bypass_hit = 1'b0;
`ifdef FETCH_BYPASS_EN
    if (!exp_valid && m_pending && !m_killed && mem_valid && !branch) begin
      bypass_hit = 1'b1;
      exp_valid  = 1'b1;
      exp_out    = resp_data;
      exp_next   = m_pend_addr + 16'd1;
    end
`endif
    exp_req = !m_pending && (exp_q.size() < DEPTH) && !branch;
    checkOutput("instr_valid", {31'b0, InstructValid}, {31'b0, exp_valid});
    checkOutput("instr_out", {16'b0, InstructOut}, {16'b0, exp_out});
    checkOutput("next_pc", {16'b0, NextPCOut}, {16'b0, exp_next});
    checkOutput("imem_req", {31'b0, IMemReq}, {31'b0, exp_req});
    if (exp_req) checkOutput("imem_addr", {16'b0, IMemAddr}, {16'b0, m_pc});

    if (mem_valid) mem_busy = 0;
    else if (mem_busy) mem_delay--;
    if (IMemReq) begin
      if (mem_busy) checkOutput("one_outstanding", 32'd1, 32'd0);
      mem_busy  = 1;
      mem_delay = lat;
      mem_addr  = IMemAddr;
    end

    if (branch) begin
      exp_q.delete();
      m_pc = target;
      if (mem_valid) begin
        m_pending = 0;
        m_killed  = 0;
      end else if (m_pending) begin
        m_killed = 1;
      end
    end else begin
      if (exp_valid && !stall && !bypass_hit) void'(exp_q.pop_front());
      if (mem_valid) begin
        if (!m_killed && !(bypass_hit && !stall)) exp_q.push_back({resp_data, m_pend_addr});
        m_pending = 0;
        m_killed  = 0;
      end
      if (exp_req) begin
        m_pending   = 1;
        m_pend_addr = m_pc;
        m_pc        = m_pc + 16'd1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; Branch = 1'b0; CalculatedPC = 16'h0;
    IMemValid = 1'b1; IMemData = 16'hDEAD;

    // reset with a stray response strobe that must be ignored
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_valid", {31'b0, InstructValid}, 32'd0);
    checkOutput("rst_req", {31'b0, IMemReq}, 32'd0);
    checkOutput("rst_out", {16'b0, InstructOut}, 32'd0);
    checkOutput("rst_next", {16'b0, NextPCOut}, 32'd0);
    IMemValid = 1'b0;

    // streaming at latency 1
    lat = 1;
    repeat (12) applyStimulus(0, 0, 16'h0);

    // long stall fills the queue, then drains
    lat = 2;
    repeat (10) applyStimulus(1, 0, 16'h0);
    checkOutput("stall_full", exp_q.size(), DEPTH);
    repeat (10) applyStimulus(0, 0, 16'h0);

    // branch while a response is pending and not yet arriving
    lat = 3;
    for (int i = 0; i < 20 && !(m_pending && !(mem_busy && mem_delay == 1)); i++)
      applyStimulus(0, 0, 16'h0);
    checkOutput("wait_pending", {31'b0, m_pending}, 32'd1);
    applyStimulus(0, 1, 16'h0040);
    repeat (12) applyStimulus(0, 0, 16'h0);

    // branch in the same cycle as the response, with stall
    lat = 2;
    for (int i = 0; i < 20 && !(m_pending && !m_killed && mem_busy && mem_delay == 1); i++)
      applyStimulus(1, 0, 16'h0);
    checkOutput("wait_resp", {31'b0, mem_busy}, 32'd1);
    applyStimulus(1, 1, 16'h1234);
    checkOutput("drop_empty", exp_q.size(), 0);
    repeat (6) applyStimulus(1, 0, 16'h0);
    repeat (6) applyStimulus(0, 0, 16'h0);

    // wrap from 16'hFFFF to 16'h0000
    lat = 1;
    applyStimulus(0, 1, 16'hFFFF);
    repeat (10) applyStimulus(0, 0, 16'h0);

`ifdef FETCH_BYPASS_EN
    // same-cycle forwarding into an empty queue
    override_en = 1; override_data = 16'hA5A5;
    for (int i = 0; i < 20 && !(exp_q.size() == 0 && m_pending && !m_killed && mem_busy && mem_delay == 1); i++)
      applyStimulus(0, 0, 16'h0);
    applyStimulus(0, 0, 16'h0);
    checkOutput("bypass_data", {16'b0, InstructOut}, 32'h0000A5A5);
    override_en = 0;
`endif

    // random traffic
    for (int i = 0; i < 300; i++) begin
      if ((i % 25) == 0) lat = $urandom_range(1, 3);
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // runaway guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter FIFO_DEPTH, 2, prefetch queue entries (legal 2..4).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 Stall  input  1  downstream decode not accepting the current instruction.
REQ-006 Branch  input  1  redirect request, valid for one cycle.
REQ-007 CalculatedPC  input  16  redirect target, sampled when Branch=1.
REQ-008 IMemReq  output  1  instruction memory read request, one cycle per request.
REQ-009 IMemAddr  output  16  word address of the request, valid with IMemReq.
REQ-010 IMemValid  input  1  response strobe, one or more cycles after the request.
REQ-011 IMemData  input  16  instruction word, valid with IMemValid.
REQ-012 InstructOut  output  16  instruction presented to decode.
REQ-013 NextPCOut  output  16  address of InstructOut plus 1, modulo 2^16.
REQ-014 InstructValid  output  1  InstructOut/NextPCOut are valid.

Function
REQ-015 The block SHALL be word-addressed: sequential PC = PC+1, wrapping 16'hFFFF -> 16'h0000.
REQ-016 At most one memory request SHALL be outstanding.
REQ-017 FSM states SHALL be FETCH (may issue), WAIT (response pending) and DISCARD (pending response to be dropped).
REQ-018 In FETCH, IMemReq=1 and IMemAddr=PC SHALL be asserted iff occupancy < FIFO_DEPTH and Branch=0; PC then increments and the FSM goes to WAIT.
REQ-019 In WAIT, IMemValid=1 SHALL push {IMemData, request address} into the queue and return the FSM to FETCH.
REQ-020 Head-entry outputs: InstructValid=1, InstructOut=instruction, NextPCOut=address+1; empty queue: all three outputs are 0.
REQ-021 Pop SHALL occur when InstructValid=1 and Stall=0.
REQ-022 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 Branch=1 SHALL, on that edge, flush the queue, load PC=CalculatedPC and suppress IMemReq in that cycle.
REQ-024 Branch=1 in WAIT with no IMemValid SHALL move the FSM to DISCARD.
REQ-025 In DISCARD, the next IMemValid SHALL be dropped, and the FSM SHALL return to FETCH.
REQ-026 Branch=1 in the same cycle as IMemValid SHALL drop the response and return the FSM to FETCH.
REQ-027 Branch SHALL take priority over Stall, push and pop.
REQ-028 With FETCH_BYPASS_EN undefined, minimum latency SHALL be: request edge t -> IMemValid at cycle t+k -> InstructValid at cycle t+k+1.

Reset
REQ-029 rst=1 SHALL set PC=RESET_PC, queue empty, FSM=FETCH, IMemReq=0, InstructValid=0, InstructOut=0, NextPCOut=0.
REQ-030 IMemValid during a reset cycle SHALL be ignored.
REQ-031 Instruction memory SHALL share rst, so no pre-reset response arrives after reset.
REQ-032 The first request SHALL issue in the first cycle after rst deasserts.

Configuration
REQ-033 Macro FETCH_BYPASS_EN defined: when the queue is empty, the FSM is in WAIT and IMemValid=1, IMemData SHALL drive InstructOut/InstructValid combinationally in that cycle.
REQ-034 Under FETCH_BYPASS_EN, the bypassed word SHALL be enqueued only if Stall=1.
REQ-035 Macro FETCH_BYPASS_EN undefined: responses SHALL always be enqueued first, per REQ-028.

Structure
REQ-036 Shared package cpu_pkg SHALL hold: word width 16, RESET_PC default, and the fetch FSM state encoding.
REQ-037 The queue SHALL be a sub-module fetch_fifo: synchronous FIFO, push/pop/flush, occupancy count, 32-bit entries.

Verification
REQ-038 Reset release, memory latency 1, Stall=0 -> IMemAddr 0,1,2,... one request every 2 cycles; InstructOut follows IMemData; NextPCOut 1,2,3.
REQ-039 Stall held for 10 cycles -> queue fills to FIFO_DEPTH; IMemReq stays 0; InstructOut holds; no entry lost after Stall drops.
REQ-040 Branch=1 with CalculatedPC=16'h0040 while a response is pending -> next response discarded; next IMemAddr=16'h0040; InstructValid=0 until that word returns.
REQ-041 Branch and IMemValid in the same cycle, with Stall=1 -> response dropped; queue empty; PC=target.
REQ-042 PC=16'hFFFF -> request 16'hFFFF then 16'h0000; NextPCOut=16'h0000 for the 16'hFFFF word.
REQ-043 FETCH_BYPASS_EN defined, empty queue, IMemValid with 16'hA5A5 -> InstructValid=1, InstructOut=16'hA5A5 in the same cycle.
